// File: rtl/cceip_sizer_pkg.sv
// cceip_sizer_pkg: state encoding and tkeep helpers shared by the
// CCEIP output stream sizer.
package cceip_sizer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Keep vectors are zero-extended to this width before the helpers.
    localparam int MAX_KEEP_W = 128;
    localparam int POP_W      = 8;

    function automatic logic [POP_W-1:0] popcount(
        input logic [MAX_KEEP_W-1:0] keep
    );
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            n = n + POP_W'(keep[i]);
        end
        return n;
    endfunction

    function automatic logic keep_contig(
        input logic [MAX_KEEP_W-1:0] keep
    );
        return (keep & (keep + MAX_KEEP_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/cceip_sync_fifo.sv
// cceip_sync_fifo: synchronous first-word-fall-through FIFO; mark_last
// sets the MSB of the newest stored entry.
module cceip_sync_fifo
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = 512
) (
    input  logic                    ap_clk,
    input  logic                    areset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    mark_last,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is flushed by the pointer reset, so it carries no reset.
    always_ff @(posedge ap_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end else if (mark_last && !empty) begin
            mem[wr_ptr - AW'(1)][WIDTH-1] <= 1'b1;
        end
    end

endmodule

// File: rtl/cceip_out_stream_sizer.sv
// cceip_out_stream_sizer: buffers a CCEIP egress frame, counts its bytes
// and caps it at max_bytes. CCEIP_SIZER_TKEEP_CHECK_EN adds tkeep_err.
module cceip_out_stream_sizer
    import cceip_sizer_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 512,
    parameter int SIZE_WIDTH = 64
) (
    input  logic                    ap_clk,
    input  logic                    areset,
    input  logic                    ctrl_start,
    input  logic [SIZE_WIDTH-1:0]   max_bytes,
    output logic                    ctrl_done,
    output logic [SIZE_WIDTH-1:0]   byte_count,
    output logic                    byte_count_valid,
    output logic                    overflow_err,
`ifdef CCEIP_SIZER_TKEEP_CHECK_EN
    output logic                    tkeep_err,
`endif
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tlast
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                state;
    logic [SIZE_WIDTH-1:0] max_q;
    logic [SIZE_WIDTH-1:0] beat_bytes;
    logic [SIZE_WIDTH-1:0] next_count;
    logic [MAX_KEEP_W-1:0] keep_ext;
    logic                  accept;
    logic                  over;
    logic                  push;
    logic                  mark;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH:0]   fifo_dout;

    assign keep_ext      = MAX_KEEP_W'(s_axis_tkeep);
    assign beat_bytes    = SIZE_WIDTH'(popcount(keep_ext));
    assign next_count    = byte_count + beat_bytes;
    assign over          = next_count > max_q;

    // Once oversize, the rest of the frame is swallowed even when full.
    assign s_axis_tready = (state == RUN) && (overflow_err || !fifo_full);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign push          = accept && !overflow_err && !over;
    assign mark          = accept && !overflow_err && over;

    assign m_axis_tvalid = !fifo_empty;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tdata  = fifo_empty ? '0 : fifo_dout[DATA_WIDTH-1:0];

    // A lone head entry may leave this cycle, so the marker also shows here.
    assign m_axis_tlast  = !fifo_empty &&
                           (fifo_dout[DATA_WIDTH] ||
                            (mark && fifo_count == CW'(1)));

    cceip_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ap_clk    (ap_clk),
        .areset    (areset),
        .push      (push),
        .din       ({s_axis_tlast, s_axis_tdata}),
        .mark_last (mark),
        .pop       (pop),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state            <= IDLE;
            max_q            <= '0;
            byte_count       <= '0;
            byte_count_valid <= 1'b0;
            overflow_err     <= 1'b0;
            ctrl_done        <= 1'b0;
        end else begin
            ctrl_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ctrl_start) begin
                        max_q            <= max_bytes;
                        byte_count       <= '0;
                        byte_count_valid <= 1'b0;
                        overflow_err     <= 1'b0;
                        state            <= RUN;
                    end
                end
                RUN: begin
                    if (push) byte_count <= next_count;
                    if (mark) overflow_err <= 1'b1;
                    if (accept && s_axis_tlast) state <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        ctrl_done        <= 1'b1;
                        byte_count_valid <= 1'b1;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CCEIP_SIZER_TKEEP_CHECK_EN
    logic keep_bad;

    assign keep_bad = !keep_contig(keep_ext) ||
                      (!s_axis_tlast && s_axis_tkeep != '1);

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            tkeep_err <= 1'b0;
        end else if (state == IDLE && ctrl_start) begin
            tkeep_err <= 1'b0;
        end else if (accept && keep_bad) begin
            tkeep_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/cceip_out_stream_sizer.md
Name: cceip_out_stream_sizer

Overview:
- Sits between the CCEIP engine's egress AXI4-Stream and the kernel's AXI4 write master stream input.
- Buffers the output frame in a synchronous FIFO and forwards it unchanged (tdata/tlast).
- Counts valid bytes per frame from tkeep and reports the final byte count, which the kernel control FSM writes to output_size_addr.
- Enforces a caller-supplied maximum output size so an oversize frame cannot overrun the host buffer.

Parameters:
- DATA_WIDTH, 64, stream data width in bits; multiple of 8.
- FIFO_DEPTH, 512, buffer depth in beats; power of 2, at least 4.
- SIZE_WIDTH, 64, width of byte counter and max_bytes.

Ports:
- ap_clk  in  1  clock.
- areset  in  1  reset. Synchronous, active-high, on ap_clk.
- ctrl_start  in  1  one-cycle pulse; arms block for one frame.
- max_bytes  in  SIZE_WIDTH  output buffer capacity in bytes; sampled on accepted ctrl_start.
- ctrl_done  out  1  one-cycle pulse when the frame is fully drained downstream.
- byte_count  out  SIZE_WIDTH  bytes accepted into FIFO for current/last frame.
- byte_count_valid  out  1  high from ctrl_done until next accepted ctrl_start.
- overflow_err  out  1  frame exceeded max_bytes; cleared on next accepted ctrl_start.
- s_axis_tvalid  in  1  engine egress valid.
- s_axis_tready  out  1  engine egress ready.
- s_axis_tdata  in  DATA_WIDTH  engine egress data.
- s_axis_tkeep  in  DATA_WIDTH/8  byte enables; low-aligned contiguous.
- s_axis_tlast  in  1  end of frame.
- m_axis_tvalid  out  1  to write master.
- m_axis_tready  in  1  from write master.
- m_axis_tdata  out  DATA_WIDTH  to write master.
- m_axis_tlast  out  1  end of frame.

Behaviour:
- Reset: state IDLE, FIFO flushed, all outputs 0, count 0, max latch 0. A reset mid-frame discards the buffered data; no ctrl_done is issued.
- States:
  - IDLE: s_axis_tready=0. On ctrl_start, latch max_bytes, clear byte_count, byte_count_valid and overflow_err, then go to RUN.
  - RUN: s_axis_tready = !fifo_full. An accepted beat (tvalid & tready) is pushed and byte_count += popcount(tkeep). An accepted beat with tlast goes to DRAIN.
  - DRAIN: s_axis_tready=0. When the FIFO is empty and no output beat is pending, go to DONE.
  - DONE: ctrl_done=1 for exactly one cycle, byte_count_valid<=1, then go to IDLE.
- ctrl_start outside IDLE is ignored. ctrl_start in the same cycle as the DONE exit is ignored.
- Oversize frame:
  - If byte_count + popcount(tkeep) > max latch, that beat and all later beats up to and including tlast are accepted (tready=1, regardless of FIFO full) but not pushed and not counted.
  - overflow_err<=1 (sticky).
  - The tlast beat of a dropped frame still ends RUN. The m_axis_tlast of the last pushed beat is forced to 1 at overflow: push a tlast marker by setting the tlast bit on the final FIFO entry. If the FIFO is empty, no marker is needed.
- Zero-length frame: tlast with tkeep=0 is counted as 0 bytes and pushed with tlast. byte_count=0 at done.
- FIFO:
  - Registered first-word-fall-through.
  - Accept-to-m_axis_tvalid latency is 1 cycle when the FIFO is empty.
  - Full throughput of 1 beat/cycle with m_axis_tready held high.
  - Simultaneous push and pop at full is allowed only if the pop frees a slot. tready is computed from the registered full flag, not from the pop.
- m_axis outputs hold stable while tvalid & !tready (AXIS rule).
- Arithmetic: counter wraps modulo 2^SIZE_WIDTH. In practice the max_bytes check prevents the wrap. popcount is computed combinationally over DATA_WIDTH/8 bits.

Optional Feature:
- CCEIP_SIZER_TKEEP_CHECK_EN defined: an accepted beat in RUN with non-contiguous tkeep, or tkeep!=all-ones on a non-tlast beat, sets the sticky output tkeep_err. tkeep_err is cleared on accepted ctrl_start, and the beat is still passed through.
- Undefined: the tkeep_err port is absent and no check is made.

Decomposition:
- Package cceip_sizer_pkg: state enum (IDLE, RUN, DRAIN, DONE) and the popcount function for the keep width.
- Sub-module cceip_sync_fifo: parameterised width/depth synchronous FWFT FIFO with full/empty/count, reset via areset.

Test Plan:
- Start with max_bytes=4096, then 8 full beats (tkeep=0xFF), the last with tlast, with m_axis_tready=1 → 8 beats out, tlast on beat 8, byte_count=64, ctrl_done one pulse, overflow_err=0.
- A 3-beat frame whose last beat has tkeep=0x07 → byte_count=19, last output tdata bit-exact.
- max_bytes=20, 4 full beats → first 2 beats forwarded with tlast on beat 2, overflow_err=1, byte_count=16, ctrl_done after the drain.
- m_axis_tready=0 while pushing FIFO_DEPTH+5 beats → s_axis_tready falls after 512 beats. Release tready → all beats arrive in order with no loss or duplicate.
- A single beat with tlast and tkeep=0 → one output beat with tlast, byte_count=0.
- areset asserted mid-RUN with the FIFO half full → m_axis_tvalid=0 next cycle, no ctrl_done. A new ctrl_start frame then completes normally.
